// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer slice.
package timer_pkg;

  typedef enum logic [1:0] {
    TC_IDLE    = 2'b00,
    TC_COUNT   = 2'b01,
    TC_EXPIRED = 2'b10
  } tcore_state_t;

  localparam int unsigned TIMER_WIDTH = 32;

  // Mode encodings used by the control FSM that drives this core
  localparam logic [1:0] OFF      = 2'b00;
  localparam logic [1:0] ONE_SHOT = 2'b01;
  localparam logic [1:0] PERIODIC = 2'b10;
  localparam logic [1:0] PWM      = 2'b11;

endpackage

// File: rtl/timer_count_core_if.sv
// Control/status bundle between the timer control FSM (master) and the count core (slave).
interface timer_count_core_if #(
    parameter int unsigned WIDTH = timer_pkg::TIMER_WIDTH
);
    logic             enable;
    logic             reload;
    logic             auto_reload;
    logic             pwm_mode;
    logic             cfg_wr;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_compare;
    logic [WIDTH-1:0] current_count;
    logic             zero_pulse;
    logic             pwm_out;
    logic             busy;
    logic             cfg_pending;

    modport master (
        output enable, reload, auto_reload, pwm_mode, cfg_wr, cfg_period, cfg_compare,
        input  current_count, zero_pulse, pwm_out, busy, cfg_pending
    );

    modport slave (
        input  enable, reload, auto_reload, pwm_mode, cfg_wr, cfg_period, cfg_compare,
        output current_count, zero_pulse, pwm_out, busy, cfg_pending
    );
endinterface

// File: rtl/timer_shadow_regs.sv
// Shadow/active period and compare registers; shadow is promoted only on an apply event.
module timer_shadow_regs
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic             prescaled_clk,
    input  logic             reset_n,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_compare,
    input  logic             apply,
    output logic [WIDTH-1:0] active_period,
    output logic [WIDTH-1:0] active_compare,
    output logic [WIDTH-1:0] next_period,
    output logic             cfg_pending
);
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_compare;
    logic [WIDTH-1:0] next_compare;

    // A write coinciding with apply bypasses the shadow and lands directly in the active regs
    assign next_period  = cfg_wr ? cfg_period  : shadow_period;
    assign next_compare = cfg_wr ? cfg_compare : shadow_compare;

    always_ff @(posedge prescaled_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_period  <= '0;
            shadow_compare <= '0;
            active_period  <= '0;
            active_compare <= '0;
            cfg_pending    <= 1'b0;
        end else if (apply) begin
            shadow_period  <= next_period;
            shadow_compare <= next_compare;
            active_period  <= next_period;
            active_compare <= next_compare;
            cfg_pending    <= 1'b0;
        end else if (cfg_wr) begin
            shadow_period  <= cfg_period;
            shadow_compare <= cfg_compare;
            cfg_pending    <= 1'b1;
        end
    end
endmodule

// File: rtl/timer_count_core.sv
// Timer down-counter: live count, terminal-count pulse, registered PWM and state tracking.
module timer_count_core
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic               prescaled_clk,
    input  logic               reset_n,
    timer_count_core_if.slave  tif
);
    tcore_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_period, active_compare, next_period;
    logic             zero_q, zero_d;
    logic             pwm_q, pwm_d;
    logic             terminal, apply, cfg_pending;

    // reload outranks the terminal event, so a reload at count 0 never pulses
    assign terminal = (state_q == TC_COUNT) && tif.enable && !tif.reload && (count_q == '0);
    assign apply    = tif.reload || (terminal && tif.auto_reload);

    timer_shadow_regs #(.WIDTH(WIDTH)) u_shadow (
        .prescaled_clk  (prescaled_clk),
        .reset_n        (reset_n),
        .cfg_wr         (tif.cfg_wr),
        .cfg_period     (tif.cfg_period),
        .cfg_compare    (tif.cfg_compare),
        .apply          (apply),
        .active_period  (active_period),
        .active_compare (active_compare),
        .next_period    (next_period),
        .cfg_pending    (cfg_pending)
    );

    always_ff @(posedge prescaled_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TC_IDLE;
            count_q <= '0;
            zero_q  <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        zero_d  = zero_q;
        pwm_d   = pwm_q;

        // With enable low and no reload every output is frozen
        if (tif.reload || tif.enable) begin
            zero_d = terminal;
            pwm_d  = tif.pwm_mode && (state_q != TC_IDLE) && (count_q < active_compare);
        end

        if (tif.reload) begin
            state_d = TC_COUNT;
            count_d = next_period;
        end else if (terminal) begin
            if (tif.auto_reload) begin
                count_d = next_period;
            end else begin
                state_d = TC_EXPIRED;
            end
        end else if ((state_q == TC_COUNT) && tif.enable) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    assign tif.current_count = count_q;
    assign tif.zero_pulse    = zero_q;
    assign tif.pwm_out       = pwm_q;
    assign tif.busy          = (state_q == TC_COUNT);
    assign tif.cfg_pending   = cfg_pending;
endmodule

// File: doc/timer_count_core.md
Name: timer_count_core

Overview:
Down-counter datapath for the programmable timer. It sits directly downstream of the timer control FSM, which drives enable, reload and mode. This block holds the live count and returns current_count to that FSM. It also produces the terminal-count pulse and the registered PWM output, and uses shadowed period/compare registers so configuration updates never glitch mid-period.

Parameters:
WIDTH, 32, bit width of count, period and compare registers.

Ports:
prescaled_clk  input  1  timer clock; all state changes on rising edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  count-enable from control FSM; decrement allowed when high.
reload  input  1  single-cycle pulse: load count from active period and (re)start counting.
auto_reload  input  1  1 = periodic (reload on terminal count); 0 = one-shot (stop at 0).
pwm_mode  input  1  1 = pwm_out driven by compare; 0 = pwm_out forced low.
cfg_wr  input  1  single-cycle pulse: capture cfg_period/cfg_compare into shadow registers.
cfg_period  input  WIDTH  new period value (count reloads to this).
cfg_compare  input  WIDTH  new PWM compare value.
current_count  output  WIDTH  live counter value, registered.
zero_pulse  output  1  one-cycle pulse when count transitions through terminal count.
pwm_out  output  1  registered PWM waveform.
busy  output  1  high while in COUNT state.
cfg_pending  output  1  shadow holds values not yet applied to active registers.

Behaviour:
- Reset (async, reset_n low): state IDLE; current_count, active_period, active_compare, shadow regs = 0; zero_pulse, pwm_out, busy, cfg_pending = 0.
- States:
  - IDLE: after reset; counter holds.
  - COUNT: counting.
  - EXPIRED: one-shot finished; count holds 0.
- Transitions:
  - reload in any state -> COUNT.
  - COUNT, terminal event with auto_reload=0 -> EXPIRED.
  - No other exits; only reset returns to IDLE.
- Shadow update:
  - cfg_wr latches cfg_period/cfg_compare into shadow and sets cfg_pending=1 next cycle.
  - Shadow is copied to active regs only on a reload pulse or an auto-reload terminal event; cfg_pending clears in that same cycle.
  - If cfg_wr coincides with an apply event, the new cfg values bypass the shadow and are applied directly; cfg_pending stays 0.
- Counting (COUNT, enable=1, no reload):
  - current_count > 0: current_count <= current_count - 1.
  - current_count == 0 (terminal event): zero_pulse=1 for one cycle (registered, asserted the cycle after the edge that saw count 0).
    - auto_reload=1: count <= active_period (post-apply value), stay COUNT.
    - auto_reload=0: count holds 0, go to EXPIRED.
- enable=0: count, state and outputs hold; no terminal event is generated.
- Priority: reset > reload > terminal event > decrement.
  - reload loads the period (post-apply) regardless of enable.
  - reload never produces zero_pulse, even if the count was 0.
- Period 0 with auto_reload=1: zero_pulse on every enabled cycle. Period 0 one-shot: zero_pulse once, then EXPIRED.
- No wrap-around: count never decrements below 0.
- PWM, registered, one-cycle latency from current_count:
  - pwm_out <= pwm_mode && (state==COUNT || state==EXPIRED) && (current_count < active_compare), unsigned compare.
  - compare=0 -> always low.
  - compare > period -> always high while counting.
  - In IDLE pwm_out=0.
- busy = (state==COUNT), registered with the state.
- Arithmetic is unsigned WIDTH bits; no carry outputs.

Decomposition:
- Package timer_pkg holds:
  - state enum tcore_state_t {TC_IDLE, TC_COUNT, TC_EXPIRED}, 2-bit.
  - constant TIMER_WIDTH=32.
  - mode encoding constants shared with the control FSM: OFF=2'b00, ONE_SHOT=2'b01, PERIODIC=2'b10, PWM=2'b11.
- One natural sub-module, timer_shadow_regs: shadow/active period and compare registers plus the cfg_pending/apply logic.
- The counter, state machine and PWM compare stay in the top module.

Test Plan:
1. Reset, cfg_wr period=5 compare=2, reload, enable=1, auto_reload=1 -> count 5,4,3,2,1,0,5,...; zero_pulse every 6 enabled cycles; pwm_out high when count is 1 or 0 (1-cycle lag).
2. One-shot (auto_reload=0): period=3, reload -> count 3,2,1,0, then holds 0; single zero_pulse; busy drops; state EXPIRED; a second reload restarts from 3.
3. Mid-period cfg_wr period=10 while counting period=5 -> cfg_pending=1; old period completes; count reloads to 10 at terminal; cfg_pending clears in that cycle.
4. cfg_wr and reload in the same cycle with period=7 -> count=7 next cycle; cfg_pending never asserts. Reload while count=0 -> no zero_pulse.
5. Period=0, auto_reload=1, enable=1 -> zero_pulse high every cycle. Toggle enable=0 for 3 cycles -> count, pulse and pwm_out frozen.
6. Assert reset_n low asynchronously mid-count (count=4) -> all outputs 0 immediately; after release the block stays in IDLE until reload. Also check pwm_mode=0 -> pwm_out=0 throughout.
